// File: rtl/oserdes_burst.sv
// Soft serializer for DDR3 DQ/DQS byte lanes: parallel words in over valid/ready,
// one bit per lane per clock out, tristate enable stretched by preamble/postamble.
module oserdes_burst #(
  parameter int   LANES     = 8,
  parameter int   WIDTH     = 4,
  parameter int   PREAMBLE  = 1,
  parameter int   POSTAMBLE = 1,
  parameter logic INIT_OUT  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES*WIDTH-1:0] din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [LANES-1:0]       dout,
  output logic                   tout,
  output logic                   busy
);

  localparam int             CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [2:0]     PRE_LAST  = (PREAMBLE > 0)  ? 3'(PREAMBLE - 1)  : 3'd0;
  localparam logic [2:0]     POST_LAST = (POSTAMBLE > 0) ? 3'(POSTAMBLE - 1) : 3'd0;
  localparam logic [LANES-1:0] IDLE_OUT = {LANES{INIT_OUT}};

  typedef enum logic [1:0] {IDLE, PRE, DATA, POST} state_t;

  state_t                 state;
  logic [LANES*WIDTH-1:0] shreg;
  logic [CW-1:0]          bit_cnt;
  logic [2:0]             phase;
  logic [LANES-1:0]       din_bit0;
  logic [LANES-1:0]       shreg_bit0;
  logic                   xfer;

  // Every lane shifts right independently so its next bit always sits at the lane LSB.
  function automatic logic [LANES*WIDTH-1:0] shift_lanes(input logic [LANES*WIDTH-1:0] w);
    logic [LANES*WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++)
      r[k*WIDTH +: WIDTH] = w[k*WIDTH +: WIDTH] >> 1;
    return r;
  endfunction

  always_comb begin
    din_bit0   = '0;
    shreg_bit0 = '0;
    for (int k = 0; k < LANES; k++) begin
      din_bit0[k]   = din[k*WIDTH];
      shreg_bit0[k] = shreg[k*WIDTH];
    end
  end

  assign din_ready = (state == IDLE) || ((state == DATA) && (bit_cnt == LAST_BIT));
  assign xfer      = din_valid & din_ready;
  assign busy      = (state != IDLE);

  // dout/tout are loaded with the values of the state being entered, so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      phase   <= '0;
      dout    <= IDLE_OUT;
      tout    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            tout <= 1'b0;
            if (PREAMBLE > 0) begin
              state <= PRE;
              phase <= PRE_LAST;
              shreg <= din;
              dout  <= IDLE_OUT;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
              dout    <= din_bit0;
              shreg   <= shift_lanes(din);
            end
          end
        end
        PRE: begin
          if (phase == 3'd0) begin
            state   <= DATA;
            bit_cnt <= '0;
            dout    <= shreg_bit0;
            shreg   <= shift_lanes(shreg);
          end else begin
            phase <= phase - 3'd1;
          end
        end
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            if (xfer) begin
              bit_cnt <= '0;
              dout    <= din_bit0;
              shreg   <= shift_lanes(din);
            end else if (POSTAMBLE > 0) begin
              state <= POST;
              phase <= POST_LAST;
              dout  <= IDLE_OUT;
            end else begin
              state <= IDLE;
              tout  <= 1'b1;
              dout  <= IDLE_OUT;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            dout    <= shreg_bit0;
            shreg   <= shift_lanes(shreg);
          end
        end
        POST: begin
          if (phase == 3'd0) begin
            state <= IDLE;
            tout  <= 1'b1;
          end else begin
            phase <= phase - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oserdes_burst.sv
// Bench for oserdes_burst: two configurations side by side, checked against a
// per-cycle output timeline built from each accepted word.
module tb_oserdes_burst;

  localparam int   LA = 2, WA = 4, PA = 1, QA = 1;
  localparam logic IA = 1'b0;
  localparam int   LB = 3, WB = 1, PB = 0, QB = 0;
  localparam logic IB = 1'b1;
  localparam int   TL = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic [LA*WA-1:0] din_a   = '0;
  logic             valid_a = 1'b0;
  logic             ready_a;
  logic [LA-1:0]    dout_a;
  logic             tout_a;
  logic             busy_a;

  logic [LB*WB-1:0] din_b   = '0;
  logic             valid_b = 1'b0;
  logic             ready_b;
  logic [LB-1:0]    dout_b;
  logic             tout_b;
  logic             busy_b;

  always #5 clk = ~clk;

  oserdes_burst #(.LANES(LA), .WIDTH(WA), .PREAMBLE(PA), .POSTAMBLE(QA), .INIT_OUT(IA)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
    .dout(dout_a), .tout(tout_a), .busy(busy_a)
  );

  oserdes_burst #(.LANES(LB), .WIDTH(WB), .PREAMBLE(PB), .POSTAMBLE(QB), .INIT_OUT(IB)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
    .dout(dout_b), .tout(tout_b), .busy(busy_b)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   end_cyc [2];
  logic [15:0] tl_dout  [2][TL];
  logic        tl_ready [2][TL];
  int   low_cnt [2];
  int   busy_ready_cnt [2];
  logic xfer [2];

  function automatic int cfg_lanes(input int i);
    return (i == 0) ? LA : LB;
  endfunction
  function automatic int cfg_w(input int i);
    return (i == 0) ? WA : WB;
  endfunction
  function automatic int cfg_pre(input int i);
    return (i == 0) ? PA : PB;
  endfunction
  function automatic int cfg_post(input int i);
    return (i == 0) ? QA : QB;
  endfunction
  function automatic logic cfg_init(input int i);
    return (i == 0) ? IA : IB;
  endfunction

  function automatic logic [15:0] idle_vec(input int i);
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < cfg_lanes(i); k++) v[k] = cfg_init(i);
    return v;
  endfunction

  function automatic logic exp_busy(input int i, input int c);
    return c <= end_cyc[i];
  endfunction
  function automatic logic exp_ready(input int i, input int c);
    return exp_busy(i, c) ? tl_ready[i][c % TL] : 1'b1;
  endfunction
  function automatic logic [15:0] exp_dout(input int i, input int c);
    return exp_busy(i, c) ? tl_dout[i][c % TL] : idle_vec(i);
  endfunction

  // A word accepted while presenting cycle c: lay out its preamble (only when starting
  // from idle), data bits and postamble on the timeline, replacing any pending postamble.
  task automatic record_transfer(input int i, input logic [31:0] word, input int c);
    int          s;
    int          w;
    logic [15:0] bits;
    w = cfg_w(i);
    if (c > end_cyc[i]) begin
      for (int p = 0; p < cfg_pre(i); p++) begin
        tl_dout[i][(c + 1 + p) % TL]  = idle_vec(i);
        tl_ready[i][(c + 1 + p) % TL] = 1'b0;
      end
      s = c + 1 + cfg_pre(i);
    end else begin
      s = c + 1;
    end
    for (int j = 0; j < w; j++) begin
      bits = '0;
      for (int k = 0; k < cfg_lanes(i); k++) bits[k] = word[k*w + j];
      tl_dout[i][(s + j) % TL]  = bits;
      tl_ready[i][(s + j) % TL] = (j == w - 1);
    end
    for (int p = 0; p < cfg_post(i); p++) begin
      tl_dout[i][(s + w + p) % TL]  = idle_vec(i);
      tl_ready[i][(s + w + p) % TL] = 1'b0;
    end
    end_cyc[i] = s + w + cfg_post(i) - 1;
  endtask

  task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s at cycle %0d: observed %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkOutput();
    compare("a.dout",      16'(dout_a),  exp_dout(0, cyc));
    compare("a.tout",      16'(tout_a),  16'(!exp_busy(0, cyc)));
    compare("a.din_ready", 16'(ready_a), 16'(exp_ready(0, cyc)));
    compare("a.busy",      16'(busy_a),  16'(exp_busy(0, cyc)));
    compare("b.dout",      16'(dout_b),  exp_dout(1, cyc));
    compare("b.tout",      16'(tout_b),  16'(!exp_busy(1, cyc)));
    compare("b.din_ready", 16'(ready_b), 16'(exp_ready(1, cyc)));
    compare("b.busy",      16'(busy_b),  16'(exp_busy(1, cyc)));
    if (tout_a === 1'b0) low_cnt[0]++;
    if (tout_b === 1'b0) low_cnt[1]++;
    if (busy_a === 1'b1 && ready_a === 1'b1) busy_ready_cnt[0]++;
    if (busy_b === 1'b1 && ready_b === 1'b1) busy_ready_cnt[1]++;
  endtask

  // One clock: check at the falling edge, drive new inputs, commit the handshake at the rising edge.
  task automatic applyStimulus(input logic va, input logic [31:0] wa,
                               input logic vb, input logic [31:0] wb);
    logic [31:0] ma;
    logic [31:0] mb;
    @(negedge clk);
    checkOutput();
    ma      = wa & ((32'd1 << (LA*WA)) - 32'd1);
    mb      = wb & ((32'd1 << (LB*WB)) - 32'd1);
    din_a   = ma[LA*WA-1:0];
    valid_a = va;
    din_b   = mb[LB*WB-1:0];
    valid_b = vb;
    xfer[0] = va && exp_ready(0, cyc);
    xfer[1] = vb && exp_ready(1, cyc);
    @(posedge clk);
    if (xfer[0]) record_transfer(0, ma, cyc);
    if (xfer[1]) record_transfer(1, mb, cyc);
    cyc++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int guard;
    end_cyc[0] = -1;
    end_cyc[1] = -1;
    low_cnt[0] = 0;
    low_cnt[1] = 0;
    busy_ready_cnt[0] = 0;
    busy_ready_cnt[1] = 0;

    // Reset held across several clocks
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput();
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Single word: A5 on the 2x4 lane, a single-bit word on the 3x1 lane
    low_cnt[0] = 0;
    low_cnt[1] = 0;
    applyStimulus(1'b1, 32'hA5, 1'b1, 32'h5);
    repeat (10) applyStimulus(1'b0, $urandom, 1'b0, $urandom);
    compare("a.single_tout_low", 16'(low_cnt[0]), 16'(PA + WA + QA));
    compare("b.single_tout_low", 16'(low_cnt[1]), 16'(PB + WB + QB));

    // Three back-to-back words with din_valid held through the preamble
    low_cnt[0] = 0;
    busy_ready_cnt[0] = 0;
    n = 0;
    guard = 0;
    while (n < 3 && guard < 40) begin
      applyStimulus(1'b1, $urandom, 1'b0, 32'h0);
      if (xfer[0]) n++;
      guard++;
    end
    repeat (16) applyStimulus(1'b0, $urandom, 1'b0, 32'h0);
    compare("a.b2b_tout_low", 16'(low_cnt[0]), 16'(PA + 3*WA + QA));
    compare("a.b2b_ready_slots", 16'(busy_ready_cnt[0]), 16'd3);

    // Valid low at the last-bit slot, then raised during the postamble
    low_cnt[0] = 0;
    applyStimulus(1'b1, $urandom, 1'b0, 32'h0);
    repeat (5) applyStimulus(1'b0, $urandom, 1'b0, 32'h0);
    repeat (2) applyStimulus(1'b1, $urandom, 1'b0, 32'h0);
    repeat (12) applyStimulus(1'b0, $urandom, 1'b0, 32'h0);
    compare("a.gap_tout_low", 16'(low_cnt[0]), 16'(2*(PA + WA + QA)));

    // Random traffic on both lanes
    repeat (400)
      applyStimulus($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 5, $urandom);

    // Reset asserted mid-data, checked between clock edges
    repeat (30) applyStimulus(1'b0, $urandom, 1'b0, $urandom);
    applyStimulus(1'b1, 32'h3C, 1'b1, 32'h2);
    repeat (3) applyStimulus(1'b0, $urandom, 1'b0, $urandom);
    #2 rst_n = 1'b0;
    #1;
    end_cyc[0] = -1;
    end_cyc[1] = -1;
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;

    repeat (200)
      applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 3, $urandom);
    repeat (30) applyStimulus(1'b0, $urandom, 1'b0, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/oserdes_burst.md
# oserdes_burst

Single-clock, parametrised soft serializer for DDR3 DQ/DQS byte lanes, used where OSERDES primitives are unavailable or lanes exceed primitive width. It accepts parallel words over a valid/ready handshake, shifts them out serially one bit per clock on every lane, and generates the shared tristate enable. The tristate enable is extended by a programmable preamble before the first bit of a burst and a postamble after the last. It sits between the write-data path and the ODELAY/IOB stage, replacing per-lane serializer instances plus the external tristate logic.

## Interface
- LANES, 8: number of serial output lanes (1..16)
- WIDTH, 4: bits per lane per parallel word (1..8); bit 0 is sent first
- PREAMBLE, 1: clocks of driven-idle before the first data bit of a burst (0..7)
- POSTAMBLE, 1: clocks of driven-idle after the last data bit of a burst (0..7)
- INIT_OUT, 1'b0: value on dout while idle, in preamble/postamble, and after reset

Ports:
- clk  in  1  serial output clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- din  in  LANES*WIDTH  parallel word; lane k uses din[k*WIDTH +: WIDTH]
- din_valid  in  1  din holds a word to send
- din_ready  out  1  block accepts din this cycle; transfer when din_valid & din_ready
- dout  out  LANES  serial data, registered
- tout  out  1  tristate control, registered; 1 = high-Z, 0 = drive
- busy  out  1  high in any state other than IDLE

## Operation
- State machine: IDLE, PRE, DATA, POST. Internally: shift register (LANES*WIDTH), bit counter (clog2(WIDTH), min 1 bit), phase counter (3 bits).
- IDLE: tout=1, dout=INIT_OUT, din_ready=1. On transfer: load shift register; go PRE with count PREAMBLE, or straight to DATA if PREAMBLE=0.
- PRE: tout=0, dout=INIT_OUT, din_ready=0. After PREAMBLE cycles go DATA.
- DATA: tout=0. Each cycle, lane k outputs its next bit, LSB first. Bit counter runs 0..WIDTH-1.
  - din_ready=1 only in the cycle presenting bit WIDTH-1.
  - If a transfer occurs in that cycle, the new word loads and bit 0 follows next cycle with no gap.
  - Otherwise, go POST with count POSTAMBLE, or to IDLE if POSTAMBLE=0.
- POST: tout=0, dout=INIT_OUT, din_ready=0. After POSTAMBLE cycles go IDLE. A din_valid held during POST is accepted in the following IDLE cycle and starts a new burst with a full preamble.
- din_ready is combinational from state and bit counter only; it never depends on din_valid.
- WIDTH=1: din_ready=1 in every DATA cycle.
- din_valid without din_ready: ignored, and din is not sampled.

## Timing
- Reset (asynchronous assert, deassert synchronised by the user): state=IDLE, tout=1, dout=INIT_OUT, busy=0, din_ready=1, counters cleared.
- Reset asserted mid-burst: outputs go to reset values immediately, without waiting for a clock edge. The in-flight word is discarded.
- Transfer at edge N (IDLE):
  - busy=1 and tout=0 from N+1.
  - Lane bit 0 appears at N+1+PREAMBLE.
  - Bit WIDTH-1 appears at N+PREAMBLE+WIDTH.
- Burst of B back-to-back words: tout=0 for exactly PREAMBLE + B*WIDTH + POSTAMBLE cycles, then tout=1 and busy=0.
- Minimum idle between bursts: 1 cycle in IDLE with tout=1.
- Throughput: 1 word per WIDTH clocks within a burst.

## Test plan
- Reset: hold rst_n=0 and drive clocks -> tout=1, dout=INIT_OUT, busy=0, din_ready=1. Assert rst_n=0 mid-DATA -> same values with no clock edge required.
- Single word, LANES=2, WIDTH=4, PREAMBLE=1, POSTAMBLE=1, din=8'hA5 -> tout low 6 cycles; lane0 sequence 1,0,1,0; lane1 sequence 0,1,0,1; then tout=1.
- Three back-to-back words with din_valid held high -> din_ready pulses exactly 3 times, 4 clocks apart; 12 contiguous data bits; tout low 1+12+1 cycles.
- din_valid dropped for one cycle at the bit-3 ready slot -> POST, then IDLE. Next word gets a fresh preamble, and tout=1 for at least 1 cycle between the bursts.
- PREAMBLE=0, POSTAMBLE=0, WIDTH=1 -> first bit one cycle after the transfer; tout rises the cycle after the last bit; din_ready high in every DATA cycle.
- din_valid asserted during PRE and POST -> no transfer occurs, and din changes during those cycles do not corrupt the serialized data.
